mem_responder_8085: RTL and testbench
=====================================

Name: mem_responder_8085

Overview:
- Word-addressed memory responder: the target end of the multi-cycle 8085 processor's memory bus.
- Accepts one request at a time from the processor core, inserts a programmable number of wait states, then answers with a single-cycle ready pulse.
- Storage is 16-bit words. Benches preload and inspect it hierarchically through the array mem_reg.
- Sits between the processor core and the program/data image.

Parameters:
- ADDR_W, 8: address width in words.
- DATA_W, 16: word width.
- DEPTH, 256: number of implemented words. Must be <= 2**ADDR_W.
- WAIT_CYC, 2: wait states inserted before the response. Legal range 0..15.
- ROM_TOP, 64: first writable address. Used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request strobe. Held high by the initiator until ready.
- we  input  1  1 = write, 0 = read. Sampled with req.
- addr  input  ADDR_W  word address. Sampled with req.
- wdata  input  DATA_W  write data. Sampled with req.
- rdata  output  DATA_W  read data. Valid while ready=1.
- ready  output  1  one-cycle response pulse.
- busy  output  1  high from request acceptance through the ready cycle.
- err  output  1  error flag, qualified by ready.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - rdata=0, ready=0, busy=0, err=0, wait counter=0.
  - mem_reg contents are NOT cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req=1 at a rising edge, latch addr, we and wdata, and set busy=1.
  - If WAIT_CYC=0, go to RESP. Otherwise load counter=WAIT_CYC and go to WAIT.
- WAIT:
  - Decrement the counter at each edge.
  - When the counter reaches 1 and the edge occurs, go to RESP.
  - Inputs are ignored while in WAIT; only latched values are used.
- Commit on the edge entering RESP:
  - Write: mem_reg[latched addr] <= latched wdata.
  - Read: rdata <= mem_reg[latched addr].
  - On a write, rdata <= latched wdata (write-through echo).
- RESP:
  - ready=1 for exactly one cycle, then return to IDLE with busy=0 and ready=0.
  - rdata holds its value until the next commit.
- Latency:
  - ready is high in the cycle following edge (WAIT_CYC+1) after the accepting edge.
  - A back-to-back req is accepted no earlier than the first edge in IDLE, giving a minimum period of WAIT_CYC+2 cycles per transaction.
- Out-of-range address (addr >= DEPTH):
  - A write is dropped. A read returns 0.
  - err=1 during the ready cycle.
- req dropped by the initiator while in WAIT: the transaction still completes and ready still pulses. The initiator must not drop req before ready.
- Reset during WAIT: the transaction is aborted and no write is committed.
- Reset coincident with the commit edge: reset wins and no write is committed.
- Counter is 4 bits wide. WAIT_CYC > 15 is illegal and is flagged by a simulation-time check.

Optional Feature:
- Macro: MEM_WR_PROTECT_EN.
- Defined:
  - Writes with addr < ROM_TOP are suppressed and mem_reg is unchanged.
  - err=1 during that ready cycle.
  - rdata returns the current stored word instead of the echo.
- Undefined: every in-range address is writable and ROM_TOP is unused.

Decomposition:
- Package mem8085_pkg:
  - state enum (IDLE=2'b00, WAIT=2'b01, RESP=2'b10);
  - default widths ADDR_W/DATA_W;
  - WAIT_CNT_W=4.
- Sub-module mem_wait_ctr: loadable 4-bit down-counter with a terminal-count output. It is instanced once, and the FSM uses the terminal count for the WAIT->RESP transition.

Test Plan:
- Read, WAIT_CYC=2:
  - Stimulus: preload mem_reg[64]=16'h0003. At edge k, assert req=1, we=0, addr=64.
  - Required: busy=1 from k. ready=1 and rdata=16'h0003 only in the cycle after edge k+3. busy=0 after k+4.
- Write then read:
  - Stimulus: write addr=65, wdata=16'hABCD, then read addr=65.
  - Required: the write's ready shows rdata=16'hABCD. The read returns 16'hABCD. mem_reg[65]=16'hABCD.
- WAIT_CYC=0:
  - Stimulus: hold req high continuously for reads of addr 0..3, with mem_reg[i]=i+1.
  - Required: ready pulses every 2 cycles with rdata 1,2,3,4 in order. err=0 throughout.
- Out of range:
  - Stimulus: DEPTH=128. Read addr=200, then write 200.
  - Required: read rdata=0 with err=1 on ready. The write also gives err=1, and no location changes.
- Reset mid-transaction:
  - Stimulus: write addr=10, wdata=16'h5555, with mem_reg[10]=16'h1111. Assert reset one cycle after acceptance.
  - Required: ready, busy and rdata go to 0 immediately. mem_reg[10] stays 16'h1111. The next read of 10 returns 16'h1111.
- MEM_WR_PROTECT_EN defined:
  - Stimulus: write addr=5, wdata=16'hFFFF, with mem_reg[5]=16'h0007.
  - Required: err=1 and rdata=16'h0007 on ready. mem_reg[5] is unchanged.
  - A write to addr=64 succeeds with err=0.

Source files
------------

// File: rtl/mem8085_pkg.sv
// ============================================================================
// Module  : mem8085_pkg
// Purpose : Shared types and constants for the 8085 memory responder.
//           - state_e      : responder FSM state encoding
//           - DEF_ADDR_W   : default word-address width
//           - DEF_DATA_W   : default word width
//           - WAIT_CNT_W   : width of the wait-state counter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem8085_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_wait_ctr.sv
// ============================================================================
// Module  : mem_wait_ctr
// Purpose : Loadable down-counter that times the wait states of one memory
//           transaction. tc_o is high while the count equals 1, so the
//           consumer knows the current edge is the last wait edge.
// Ports   : clk        - system clock, rising edge
//           reset      - asynchronous active-high reset (count -> 0)
//           load_i     - load load_val_i on the next edge (priority over dec)
//           load_val_i - value to load
//           dec_i      - decrement on the next edge (saturates at 0)
//           tc_o       - terminal count, count == 1
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_ctr
    import mem8085_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [WAIT_CNT_W-1:0] load_val_i,
    input  logic                  dec_i,
    output logic                  tc_o
);

    logic [WAIT_CNT_W-1:0] count_q;
    logic [WAIT_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == WAIT_CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/mem_responder_8085.sv
// ============================================================================
// Module  : mem_responder_8085
// Purpose : Word-addressed memory target for the multi-cycle 8085 core bus.
//           Accepts one request, inserts WAIT_CYC wait states, commits the
//           access, then answers with a one-cycle ready pulse.
// Ports   : clk    - system clock, rising edge
//           reset  - asynchronous active-high reset (memory is not cleared)
//           req    - request strobe, held by the initiator until ready
//           we     - 1 = write, 0 = read (sampled with req)
//           addr   - word address (sampled with req)
//           wdata  - write data (sampled with req)
//           rdata  - read data / write echo, valid while ready = 1
//           ready  - one-cycle response pulse
//           busy   - high from acceptance through the ready cycle
//           err    - error flag, qualified by ready
// Options : MEM_WR_PROTECT_EN - when defined, writes below ROM_TOP are
//           suppressed, flagged with err and answered with the stored word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder_8085
    import mem8085_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2,
    parameter int ROM_TOP  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int                    IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WAIT_CNT_W-1:0] c_wait_load = WAIT_CNT_W'(WAIT_CYC);
    localparam bit                    c_zero_wait = (WAIT_CYC == 0);

    // Parameter sanity: the counter only holds 4 bits and the array must
    // fit inside the address space.
    if ((WAIT_CYC < 0) || (WAIT_CYC > 15) || (DEPTH > (1 << ADDR_W)) ||
        (DEPTH < 1) || (ROM_TOP < 0)) begin : g_bad_params
        $error("mem_responder_8085: illegal parameters (WAIT_CYC=%0d DEPTH=%0d ROM_TOP=%0d)",
               WAIT_CYC, DEPTH, ROM_TOP);
    end

    logic [DATA_W-1:0] mem_reg [0:DEPTH-1];

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;
    logic              busy_q;
    logic              err_q;

    logic              w_accept;
    logic              w_tc;
    logic              w_commit;
    logic [ADDR_W-1:0] w_c_addr;
    logic              w_c_we;
    logic [DATA_W-1:0] w_c_wdata;
    logic [IDX_W-1:0]  w_idx;
    logic              w_in_range;
    logic              w_wr_prot;
    logic [DATA_W-1:0] w_stored;
    logic              w_mem_we;
    logic [DATA_W-1:0] rdata_d;
    logic              err_d;

    assign w_accept = (state_q == IDLE) && req;

    // With zero wait states the commit happens on the accepting edge itself,
    // so the access must be taken from the live inputs rather than the
    // latched copies.
    assign w_commit = (state_q == IDLE) ? (req && c_zero_wait)
                                        : ((state_q == WAIT) && w_tc);

    always_comb begin
        w_c_addr  = addr_q;
        w_c_we    = we_q;
        w_c_wdata = wdata_q;
        if (state_q == IDLE) begin
            w_c_addr  = addr;
            w_c_we    = we;
            w_c_wdata = wdata;
        end
    end

    assign w_idx      = w_c_addr[IDX_W-1:0];
    assign w_in_range = ({{(32-ADDR_W){1'b0}}, w_c_addr} < 32'(DEPTH));

`ifdef MEM_WR_PROTECT_EN
    assign w_wr_prot = w_c_we && ({{(32-ADDR_W){1'b0}}, w_c_addr} < 32'(ROM_TOP));
`else
    assign w_wr_prot = 1'b0;
`endif

    // Out-of-range lookups alias inside the array, so mask them to zero.
    assign w_stored = w_in_range ? mem_reg[w_idx] : '0;

    // Writes echo their data; protected writes report the untouched word.
    assign rdata_d  = (w_c_we && !w_wr_prot) ? w_c_wdata : w_stored;
    assign err_d    = !w_in_range || w_wr_prot;

    // Reset gating here makes a reset coincident with the commit edge win.
    assign w_mem_we = w_commit && w_c_we && w_in_range && !w_wr_prot && !reset;

    mem_wait_ctr u_wait_ctr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_accept),
        .load_val_i (c_wait_load),
        .dec_i      (state_q == WAIT),
        .tc_o       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_reg[w_idx] <= w_c_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (w_accept) begin
                        addr_q  <= addr;
                        we_q    <= we;
                        wdata_q <= wdata;
                        busy_q  <= 1'b1;
                        if (w_commit) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            rdata_q <= rdata_d;
                            err_q   <= err_d;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (w_commit) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        rdata_q <= rdata_d;
                        err_q   <= err_d;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder_8085.sv
// ============================================================================
// Module  : tb_mem_responder_8085
// Purpose : Directed self-checking bench for mem_responder_8085.
//           Instance 0: defaults (WAIT_CYC=2, DEPTH=256)
//           Instance 1: WAIT_CYC=0
//           Instance 2: DEPTH=128
//           Honours MEM_WR_PROTECT_EN for the write-protect expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder_8085;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_v;
    logic [2:0]  we_v;
    logic [7:0]  addr_v  [3];
    logic [15:0] wdata_v [3];
    logic [15:0] rdata_v [3];
    logic [2:0]  ready_v;
    logic [2:0]  busy_v;
    logic [2:0]  err_v;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_responder_8085 u_a (
        .clk(clk), .reset(reset), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .rdata(rdata_v[0]), .ready(ready_v[0]), .busy(busy_v[0]),
        .err(err_v[0])
    );

    mem_responder_8085 #(.WAIT_CYC(0)) u_b (
        .clk(clk), .reset(reset), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .rdata(rdata_v[1]), .ready(ready_v[1]), .busy(busy_v[1]),
        .err(err_v[1])
    );

    mem_responder_8085 #(.DEPTH(128)) u_c (
        .clk(clk), .reset(reset), .req(req_v[2]), .we(we_v[2]), .addr(addr_v[2]),
        .wdata(wdata_v[2]), .rdata(rdata_v[2]), .ready(ready_v[2]), .busy(busy_v[2]),
        .err(err_v[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mem_wr(input int d, input logic [7:0] idx, input logic [15:0] v);
        case (d)
            0:       u_a.mem_reg[idx] = v;
            1:       u_b.mem_reg[idx] = v;
            default: u_c.mem_reg[idx[6:0]] = v;
        endcase
    endtask

    function automatic logic [15:0] mem_rd(input int d, input logic [7:0] idx);
        case (d)
            0:       return u_a.mem_reg[idx];
            1:       return u_b.mem_reg[idx];
            default: return u_c.mem_reg[idx[6:0]];
        endcase
    endfunction

    // One full transaction; lat counts edges from the accepting edge (1)
    // to the edge after which ready is seen. Ends back in IDLE.
    task automatic txn(input int d, input logic w, input logic [7:0] a,
                       input logic [15:0] wd, output logic [15:0] rd,
                       output logic e, output int lat);
        req_v[d]   = 1'b1;
        we_v[d]    = w;
        addr_v[d]  = a;
        wdata_v[d] = wd;
        lat = 0;
        rd  = '0;
        e   = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (ready_v[d]) begin
                lat = i;
                rd  = rdata_v[d];
                e   = err_v[d];
                break;
            end
        end
        req_v[d] = 1'b0;
        we_v[d]  = 1'b0;
        if (lat == 0) chk("ready_timeout", 32'(ready_v[d]), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic        e;
        int          lat;

        reset = 1'b1;
        req_v = '0;
        we_v  = '0;
        for (int i = 0; i < 3; i++) begin
            addr_v[i]  = '0;
            wdata_v[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_rdata", 32'(rdata_v[0]), 32'h0);
        chk("rst_ready", 32'(ready_v[0]), 32'h0);
        chk("rst_busy",  32'(busy_v[0]),  32'h0);
        chk("rst_err",   32'(err_v[0]),   32'h0);
        chk("rst_b_ready", 32'(ready_v[1]), 32'h0);

        // Read with WAIT_CYC=2, cycle by cycle
        mem_wr(0, 8'd64, 16'h0003);
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 8'd64;
        step();
        chk("rd_busy_k1",  32'(busy_v[0]),  32'h1);
        chk("rd_ready_k1", 32'(ready_v[0]), 32'h0);
        step();
        chk("rd_busy_k2",  32'(busy_v[0]),  32'h1);
        chk("rd_ready_k2", 32'(ready_v[0]), 32'h0);
        step();
        chk("rd_ready_k3", 32'(ready_v[0]), 32'h1);
        chk("rd_rdata_k3", 32'(rdata_v[0]), 32'h0003);
        chk("rd_busy_k3",  32'(busy_v[0]),  32'h1);
        chk("rd_err_k3",   32'(err_v[0]),   32'h0);
        req_v[0] = 1'b0;
        step();
        chk("rd_ready_k4", 32'(ready_v[0]), 32'h0);
        chk("rd_busy_k4",  32'(busy_v[0]),  32'h0);
        chk("rd_rdata_hold", 32'(rdata_v[0]), 32'h0003);

        // Write then read
        txn(0, 1'b1, 8'd65, 16'hABCD, rd, e, lat);
        chk("wr_echo", 32'(rd), 32'hABCD);
        chk("wr_err",  32'(e),  32'h0);
        chk("wr_lat",  32'(lat), 32'd3);
        txn(0, 1'b0, 8'd65, 16'h0000, rd, e, lat);
        chk("wr_readback", 32'(rd), 32'hABCD);
        chk("wr_mem65", 32'(mem_rd(0, 8'd65)), 32'hABCD);

        // WAIT_CYC=0, req held high across four reads
        for (int i = 0; i < 4; i++) mem_wr(1, 8'(i), 16'(i + 1));
        req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 8'd0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k % 2 == 1) begin
                chk($sformatf("z_ready_%0d", k), 32'(ready_v[1]), 32'h1);
                chk($sformatf("z_rdata_%0d", k), 32'(rdata_v[1]), 32'((k - 1) / 2 + 1));
                chk($sformatf("z_err_%0d", k),   32'(err_v[1]),   32'h0);
                addr_v[1] = 8'((k + 1) / 2);
            end else begin
                chk($sformatf("z_ready_%0d", k), 32'(ready_v[1]), 32'h0);
            end
        end
        req_v[1] = 1'b0;
        step();

        // Out of range, DEPTH=128
        mem_wr(2, 8'd72, 16'h7272);
        txn(2, 1'b0, 8'd200, 16'h0000, rd, e, lat);
        chk("oor_rd_rdata", 32'(rd), 32'h0);
        chk("oor_rd_err",   32'(e),  32'h1);
        txn(2, 1'b1, 8'd200, 16'hDEAD, rd, e, lat);
        chk("oor_wr_err",   32'(e),  32'h1);
        chk("oor_alias_mem", 32'(mem_rd(2, 8'd72)), 32'h7272);
        txn(2, 1'b0, 8'd72, 16'h0000, rd, e, lat);
        chk("oor_inrange_rdata", 32'(rd), 32'h7272);
        chk("oor_inrange_err",   32'(e),  32'h0);

        // Reset one cycle after acceptance of a write
        mem_wr(0, 8'd10, 16'h1111);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 8'd10; wdata_v[0] = 16'h5555;
        step();
        chk("rst_mid_busy_pre", 32'(busy_v[0]), 32'h1);
        step();
        reset = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(ready_v[0]), 32'h0);
        chk("rst_mid_busy",  32'(busy_v[0]),  32'h0);
        chk("rst_mid_rdata", 32'(rdata_v[0]), 32'h0);
        req_v[0] = 1'b0; we_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        chk("rst_mid_mem10", 32'(mem_rd(0, 8'd10)), 32'h1111);
        txn(0, 1'b0, 8'd10, 16'h0000, rd, e, lat);
        chk("rst_mid_read10", 32'(rd), 32'h1111);

        // Write protection (or plain write when the option is off)
        mem_wr(0, 8'd5, 16'h0007);
        txn(0, 1'b1, 8'd5, 16'hFFFF, rd, e, lat);
`ifdef MEM_WR_PROTECT_EN
        chk("prot_err",   32'(e),  32'h1);
        chk("prot_rdata", 32'(rd), 32'h0007);
        chk("prot_mem5",  32'(mem_rd(0, 8'd5)), 32'h0007);
`else
        chk("noprot_err",   32'(e),  32'h0);
        chk("noprot_rdata", 32'(rd), 32'hFFFF);
        chk("noprot_mem5",  32'(mem_rd(0, 8'd5)), 32'hFFFF);
`endif
        txn(0, 1'b1, 8'd64, 16'h1234, rd, e, lat);
        chk("rom_top_err",   32'(e),  32'h0);
        chk("rom_top_rdata", 32'(rd), 32'h1234);
        chk("rom_top_mem",   32'(mem_rd(0, 8'd64)), 32'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
